// File: rtl/m6809_pkg.sv
// m6809 core bus shared definitions.
// UART register map, status bits, FSM states.
package m6809_pkg;

  localparam logic [1:0] UART_DATA   = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_CTRL   = 2'd2;

  localparam int ST_RDRF = 0;
  localparam int ST_TDRE = 1;
  localparam int ST_OVR  = 2;
  localparam int ST_FE   = 3;
  localparam int ST_IRQ  = 7;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO for mem_uart.
// Extra pointer MSB separates full from empty.
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0] mem [DEPTH];
  logic [AW:0] wp_q;
  logic [AW:0] rp_q;
  logic do_pop;
  logic do_push;

  assign empty = (wp_q == rp_q);
  assign full = (wp_q[AW] != rp_q[AW])
             && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  // A pop frees the slot, so a push on full still fits.
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head = mem[rp_q[AW-1:0]];

  // Pointer update.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop) rp_q <= rp_q + 1'b1;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mem_uart.sv
// Memory-mapped 8N1 UART on the m6809 bus.
// TX and RX FSMs, control/status, RX FIFO.
import m6809_pkg::*;

module mem_uart #(
  parameter int CLK_DIV  = 16,
  parameter int RX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sel,
  input  logic       wr_n,
  input  logic [1:0] a,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       rxd,
  output logic       txd,
  output logic       irq
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

  tx_state_e tx_state_q, tx_state_d;
  rx_state_e rx_state_q, rx_state_d;

  logic [7:0] hold_q;
  logic       tdre_q;
  logic [7:0] tx_sh_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0] tx_idx_q;
  logic       tx_tick;
  logic       tx_load;
  logic       tx_bit;

  logic       rs1_q;
  logic       rs2_q;
  logic       rxs;
  logic [7:0] rx_sh_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0] rx_idx_q;
  logic       rx_tick;
  logic       rx_push;
  logic       fe_set;

  logic       rxie_q;
  logic       txie_q;
  logic       ovr_q;
  logic       fe_q;
  logic       ovr_set;

  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_head;

  logic       wr_data;
  logic       wr_ctrl;
  logic       rd_data;
  logic       rd_status;
  logic [7:0] status;

  assign wr_data = sel && !wr_n && (a == UART_DATA) && tdre_q;
  assign wr_ctrl = sel && !wr_n && (a == UART_CTRL);
  assign rd_data = sel && wr_n && (a == UART_DATA);
  assign rd_status = sel && wr_n && (a == UART_STATUS);
  assign rxs = rs2_q;

  // When full, a same-cycle pop always succeeds, so only a bare push overflows.
  assign ovr_set = rx_push && fifo_full && !rd_data;

  assign irq = (rxie_q && !fifo_empty)
            || (txie_q && tdre_q)
            || (rxie_q && (ovr_q || fe_q));

  uart_rx_fifo #(
    .DEPTH(RX_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (rx_push),
    .pop  (rd_data),
    .wdata(rx_sh_q),
    .full (fifo_full),
    .empty(fifo_empty),
    .head (fifo_head)
  );

  // FSM state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      rx_state_q <= RX_IDLE;
    end else begin
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
    end
  end

  // TX next state and serial bit.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_load = 1'b0;
    tx_bit = 1'b1;
    tx_tick = (tx_cnt_q == '0);
    unique case (tx_state_q)
      TX_IDLE: begin
        if (!tdre_q) begin
          tx_load = 1'b1;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        tx_bit = 1'b0;
        if (tx_tick) tx_state_d = TX_DATA;
      end
      TX_DATA: begin
        tx_bit = tx_sh_q[0];
        if (tx_tick && tx_idx_q == 3'd7) tx_state_d = TX_STOP;
      end
      TX_STOP: begin
        if (tx_tick) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX datapath; txd is registered so it lags the FSM by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
      tdre_q <= 1'b1;
      tx_sh_q <= '0;
      tx_cnt_q <= BIT_LAST;
      tx_idx_q <= '0;
      txd <= 1'b1;
    end else begin
      txd <= tx_bit;
      if (wr_data) hold_q <= din;
      if (tx_load) tdre_q <= 1'b1;
      else if (wr_data) tdre_q <= 1'b0;
      if (tx_state_q == TX_IDLE) tx_cnt_q <= BIT_LAST;
      else if (tx_tick) tx_cnt_q <= BIT_LAST;
      else tx_cnt_q <= tx_cnt_q - 1'b1;
      if (tx_load) begin
        tx_sh_q <= hold_q;
        tx_idx_q <= '0;
      end else if (tx_state_q == TX_DATA && tx_tick) begin
        tx_sh_q <= {1'b1, tx_sh_q[7:1]};
        tx_idx_q <= tx_idx_q + 1'b1;
      end
    end
  end

  // rxd synchroniser.
  always_ff @(posedge clk) begin
    if (reset) begin
      rs1_q <= 1'b1;
      rs2_q <= 1'b1;
    end else begin
      rs1_q <= rxd;
      rs2_q <= rs1_q;
    end
  end

  // RX next state, push and framing error.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick = (rx_cnt_q == '0);
    rx_push = 1'b0;
    fe_set = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (!rxs) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_tick) rx_state_d = rxs ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (rx_tick && rx_idx_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: begin
        if (rx_tick) begin
          rx_state_d = RX_IDLE;
          rx_push = rxs;
          fe_set = !rxs;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX datapath; idle preloads a half-bit count to hit mid start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_cnt_q <= HALF_LAST;
      rx_idx_q <= '0;
      rx_sh_q <= '0;
    end else begin
      if (rx_state_q == RX_IDLE) rx_cnt_q <= HALF_LAST;
      else if (rx_tick) rx_cnt_q <= BIT_LAST;
      else rx_cnt_q <= rx_cnt_q - 1'b1;
      if (rx_state_q == RX_START) rx_idx_q <= '0;
      else if (rx_state_q == RX_DATA && rx_tick) begin
        rx_sh_q <= {rxs, rx_sh_q[7:1]};
        rx_idx_q <= rx_idx_q + 1'b1;
      end
    end
  end

  // Control and sticky flags; a new event beats a status-read clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      rxie_q <= 1'b0;
      txie_q <= 1'b0;
      ovr_q <= 1'b0;
      fe_q <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        rxie_q <= din[0];
        txie_q <= din[1];
      end
      if (ovr_set) ovr_q <= 1'b1;
      else if (rd_status) ovr_q <= 1'b0;
      if (fe_set) fe_q <= 1'b1;
      else if (rd_status) fe_q <= 1'b0;
    end
  end

  // Status byte.
  always_comb begin
    status = '0;
    status[ST_RDRF] = !fifo_empty;
    status[ST_TDRE] = tdre_q;
    status[ST_OVR] = ovr_q;
    status[ST_FE] = fe_q;
    status[ST_IRQ] = irq;
  end

  // Read data mux.
  always_comb begin
    dout = '0;
    unique case (a)
      UART_DATA:   dout = fifo_empty ? 8'h00 : fifo_head;
      UART_STATUS: dout = status;
      UART_CTRL:   dout = {6'b0, txie_q, rxie_q};
      default:     dout = '0;
    endcase
  end

endmodule

// File: doc/mem_uart.md
# mem_uart

Memory-mapped 8N1 UART peripheral on the m6809 core bus, decoded at 0xFE00–0xFE03 alongside the ROM/RAM devices. It accepts bus writes and reads on the same `sel`/`wr_n`/`a`/`din`/`dout` scheme as the memory devices. Its `dout` feeds the core data-in mux. It serialises transmit bytes, deserialises receive bytes into a 4-entry FIFO, and raises an interrupt request.

## Interface
- `CLK_DIV`, 16: clk cycles per bit; even, ≥4.
- `RX_DEPTH`, 4: RX FIFO entries; power of 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sel`  in  1  device select from address decode (address[15:8] == 8'hFE).
- `wr_n`  in  1  bus direction: 0 = write, 1 = read.
- `a`  in  2  register offset (address[1:0]).
- `din`  in  8  write data from core.
- `dout`  out  8  read data to core; combinational from `a` and registered state.
- `rxd`  in  1  serial input; asynchronous.
- `txd`  out  1  serial output; idles high.
- `irq`  out  1  interrupt request, active high, level.

## Operation
- Register map:
  - 0 DATA: write loads the TX holding register. Read returns the FIFO head and pops it.
  - 1 STATUS (read-only):
    - b0 RDRF: FIFO non-empty.
    - b1 TDRE: holding register empty.
    - b2 OVR: sticky.
    - b3 FE: sticky.
    - b7 equals `irq`.
    - Other bits read 0.
  - 2 CTRL (r/w): b0 RXIE, b1 TXIE; other bits write-ignored and read 0.
  - 3: reads 0x00; writes ignored.
- A bus access is one clk cycle with `sel`=1. Side effects occur at the end of that cycle.
- STATUS read clears OVR and FE at the end of the cycle. The value returned shows the pre-clear state.
- DATA read when FIFO is empty returns 0x00 and changes nothing.
- DATA write when TDRE=0 is dropped; holding and shifter are unchanged.
- `irq` = (RXIE & RDRF) | (TXIE & TDRE) | (RXIE & (OVR | FE)).
- TX FSM states:
  - IDLE: if holding is full, transfer it to the shifter, set TDRE=1, go to START.
  - START: `txd`=0 for CLK_DIV cycles, then go to DATA.
  - DATA: 8 bits LSB-first, CLK_DIV cycles each, then go to STOP.
  - STOP: `txd`=1 for CLK_DIV cycles, then go to IDLE.
- TX back-to-back: a byte written during STOP starts its start bit immediately after STOP, with one IDLE cycle in between.
- RX synchroniser: `rxd` passes through a 2-flop synchroniser; `rxs` is the synchronised value.
- RX FSM states:
  - IDLE: on `rxs`=0, go to START.
  - START: sample at CLK_DIV/2 cycles. If `rxs`=1 it is a false start; return to IDLE. Otherwise go to DATA.
  - DATA: 8 samples CLK_DIV apart, LSB-first, then go to STOP.
  - STOP: one sample CLK_DIV later. Sample 1: push the byte. Sample 0: set FE, discard the byte.
  - After STOP, return to IDLE.
- FIFO push while full: byte dropped, OVR set.
- Push and pop in the same cycle while full: both succeed; OVR is not set.
- Push and pop in the same cycle while empty: the read returns 0x00 and the pushed byte is stored.
- Reset values:
  - `txd`=1, `dout` per map; STATUS=0x02, so TDRE=1.
  - CTRL=0, `irq`=0.
  - FIFO empty; both FSMs IDLE; synchroniser flops=1.
- Reset asserted mid-frame aborts immediately. `txd` is high on the cycle after the reset edge, and any partial RX byte is lost.

## Timing
- `dout` is valid in the same cycle as `sel`/`a`. There are no wait states.
- DATA write at edge N (idle TX): TDRE reads 0 in cycle N+1 and 1 in cycle N+2. `txd` falls at edge N+2.
- A frame lasts 10·CLK_DIV cycles from the `txd` fall to the end of the stop bit.
- RX latency: RDRF=1 within CLK_DIV/2 + 9·CLK_DIV + 3 cycles of the `rxd` start-bit fall. The 3 cycles cover the synchroniser and the push.
- `irq` updates on the same edge as its source flags.
- Baud and sample counters are width $clog2(CLK_DIV), and reload at 0. FIFO pointers are $clog2(RX_DEPTH)+1 bits wide, so full and empty are distinguished by the MSB.

## Structure
- `m6809_pkg` holds:
  - Register offsets: `UART_DATA`, `UART_STATUS`, `UART_CTRL`.
  - Status bit positions.
  - TX and RX FSM state enums.
- One sub-module: `uart_rx_fifo` (sync FIFO: push, pop, full, empty, head). The TX and RX FSMs stay in `mem_uart`.
- The integration layer adds `sel_uart` = (address[15:8] == 8'hFE) and a mux leg for `dout`.

## Test plan
- Reset, then read STATUS → 0x02. Check `txd`=1 and `irq`=0.
- Write 0x55 to DATA with CLK_DIV=16 → `txd` shows 0,1,0,1,0,1,0,1,0,1 at 16 cycles/bit, starting at edge N+2.
- Drive serial 0xA5 on `rxd`, then read DATA → 0xA5. STATUS then reads 0x02.
- Send 5 bytes without reading → the first 4 are returned in order and STATUS b2=1. After a STATUS read, b2=0.
- Drive a 0xFF frame with the stop bit held at 0 → FE=1 and RDRF=0. With RXIE=1, `irq`=1.
- Write 0x11, then 0x22 while TDRE=0 → only 0x11 is transmitted. Assert `reset` mid-frame → `txd`=1 on the next cycle.
